// File: rtl/guest_parking_entry.sv
// Guest-parking entry controller: owns the slot occupancy bitmap, grants the
// lowest free slot per entry request, drives the entry gate and absorbs exit releases.
module guest_parking_entry #(
  parameter  int N_SLOTS     = 20,
  parameter  int GATE_CYCLES = 8,
  localparam int IW          = $clog2(N_SLOTS),
  localparam int CW          = $clog2(N_SLOTS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entry_req,
  output logic          entry_ack,
  output logic          entry_ok,
  output logic [IW-1:0] entry_slot,
  output logic          gate_open,
  input  logic          exit_valid,
  input  logic [IW-1:0] exit_slot,
  output logic          exit_err,
  output logic [CW-1:0] avail_slots,
  output logic          full
);

  localparam int PW = 1 << IW;
  localparam int GW = $clog2(GATE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ALLOC, GATE, WAIT_DROP} state_t;

  state_t          state, next_state;
  logic [N_SLOTS-1:0] occ;
  logic [PW-1:0]   occ_pad, occ_pad_next;
  logic [GW-1:0]   gate_cnt;
  logic [IW-1:0]   alloc_idx;
  logic            free_found;
  logic            grant;
  logic            rel_valid;
  logic [CW-1:0]   avail_next;

  // Padding the bitmap to the full index range keeps out-of-range release indices harmless.
  assign occ_pad   = PW'(occ);
  assign grant     = (state == ALLOC) && free_found;
  assign rel_valid = exit_valid && (int'(exit_slot) < N_SLOTS) && occ_pad[exit_slot];
  assign gate_open = (state == GATE);

  // Scanning downward leaves the lowest free index as the final winner.
  always_comb begin
    alloc_idx  = '0;
    free_found = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        alloc_idx  = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    occ_pad_next = occ_pad;
    if (grant)     occ_pad_next[alloc_idx] = 1'b1;
    if (rel_valid) occ_pad_next[exit_slot] = 1'b0;
  end

  always_comb begin
    avail_next = avail_slots;
    if (grant && !rel_valid)      avail_next = avail_slots - CW'(1);
    else if (!grant && rel_valid) avail_next = avail_slots + CW'(1);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (entry_req) next_state = ALLOC;
      ALLOC:     next_state = free_found ? GATE : WAIT_DROP;
      GATE:      if (gate_cnt == '0) next_state = WAIT_DROP;
      WAIT_DROP: if (!entry_req) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      occ         <= '0;
      gate_cnt    <= '0;
      avail_slots <= CW'(N_SLOTS);
      full        <= 1'b0;
      entry_ack   <= 1'b0;
      entry_ok    <= 1'b0;
      entry_slot  <= '0;
      exit_err    <= 1'b0;
    end else begin
      state       <= next_state;
      occ         <= occ_pad_next[N_SLOTS-1:0];
      avail_slots <= avail_next;
      full        <= (avail_next == '0);
      entry_ack   <= (state == ALLOC);
      exit_err    <= exit_valid && !rel_valid;
      if (state == ALLOC) begin
        entry_ok <= free_found;
        gate_cnt <= GW'(GATE_CYCLES - 1);
      end else if (state == GATE && gate_cnt != '0) begin
        gate_cnt <= gate_cnt - GW'(1);
      end
      if (grant) entry_slot <= alloc_idx;
    end
  end

endmodule
